// File: rtl/md_unit.sv
// Iterative multiply/divide unit for the EX stage.
// MULT/MULTU use shift-add and DIV/DIVU use restoring shift-subtract.
// Each runs one bit per cycle on operand magnitudes, and the sign is fixed up on entry to DONE.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_by_zero_o
);

  typedef enum logic [1:0] {IDLE, CALC, DIVZERO, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_lo;    // product sign (MUL) or quotient sign (DIV)
  logic               neg_hi;    // remainder sign (DIV only)
  logic [WIDTH-1:0]   opnd;      // |multiplicand| or |divisor|
  // acc[2W:W] is the running upper half (one guard bit).
  // acc[W-1:0] holds the multiplier or dividend and collects the product low bits or the quotient.
  logic [2*WIDTH:0]   acc;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     mul_upper;
  logic [2*WIDTH:0]   mul_next;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH:0]   div_next;
  logic [2*WIDTH:0]   acc_next;

  // Magnitude of a possibly-negative operand; the most negative value maps to 2^(W-1) unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // Apply the recorded signs to the raw magnitude result.
  function automatic logic [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] raw,
                                                  input logic div, input logic nlo,
                                                  input logic nhi);
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [2*WIDTH-1:0] p;
    lo = raw[WIDTH-1:0];
    hi = raw[2*WIDTH-1:WIDTH];
    p  = raw;
    if (div) begin
      if (nlo) lo = -lo;
      if (nhi) hi = -hi;
      return {hi, lo};
    end
    return nlo ? -p : p;
  endfunction

  assign a_neg = ~op_i[0] & opdata1_i[WIDTH-1];
  assign b_neg = ~op_i[0] & opdata2_i[WIDTH-1];

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_upper = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next  = {1'b0, mul_upper, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:0], 1'b0};
    div_diff  = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b0, opnd};
    div_next  = div_diff[WIDTH+1] ? div_shift
                                  : {div_diff[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
    acc_next  = is_div ? div_next : mul_next;
  end

  // Control FSM with registered outputs and the iterative datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      is_div        <= 1'b0;
      neg_lo        <= 1'b0;
      neg_hi        <= 1'b0;
      opnd          <= '0;
      acc           <= '0;
      busy_o        <= 1'b0;
      ready_o       <= 1'b0;
      result_o      <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            is_div <= op_i[1];
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            opnd   <= abs_val(opdata2_i, b_neg);
            acc    <= {{(WIDTH+1){1'b0}}, abs_val(opdata1_i, a_neg)};
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= (op_i[1] && opdata2_i == '0) ? DIVZERO : CALC;
          end
        end
        CALC: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state         <= DONE;
              result_o      <= sign_fix(acc_next[2*WIDTH-1:0], is_div, neg_lo, neg_hi);
              div_by_zero_o <= 1'b0;
              ready_o       <= 1'b1;
            end
          end
        end
        DIVZERO: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state         <= DONE;
            result_o      <= '0;
            div_by_zero_o <= 1'b1;
            ready_o       <= 1'b1;
          end
        end
        default: begin
          // DONE: the ready pulse is already on the outputs; always return to IDLE.
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit (WIDTH=32).
// Stimulus pushes expected {result, dz, latency}, and a negedge monitor pops on every ready_o.
module tb_md_unit;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_i = 1'b0;
  logic [1:0]      op_i = 2'b00;
  logic [W-1:0]    opdata1_i = '0;
  logic [W-1:0]    opdata2_i = '0;
  logic            annul_i = 1'b0;
  logic            busy_o;
  logic            ready_o;
  logic [2*W-1:0]  result_o;
  logic            div_by_zero_o;

  md_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    int             acc_cyc;
    int             lat;
  } exp_t;

  exp_t           sb[$];
  int             cyc = 0;
  int             total = 0;
  int             bad = 0;
  logic [2*W-1:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, output logic dz);
    longint sa, sb_, q, r;
    logic [2*W-1:0] ua, ub;
    dz = 1'b0;
    sa = longint'(signed'(a));
    sb_ = longint'(signed'(b));
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    case (op)
      2'b00: return sa * sb_;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == '0) begin dz = 1'b1; return '0; end
        q = sa / sb_;
        r = sa % sb_;
        return {r[W-1:0], q[W-1:0]};
      end
      default: begin
        if (b == '0) begin dz = 1'b1; return '0; end
        return {ua % ub, ub == 0 ? ua : ua / ub} & {{W{1'b0}}, {W{1'b1}}} | ((ua % ub) << W);
      end
    endcase
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && ready_o) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {63'b0, ready_o}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("div_by_zero", {63'b0, div_by_zero_o}, {63'b0, e.dz});
        check("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
      end
    end
  end

  // Drive one request when idle; optionally record its expectation. Returns at the first busy cycle.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    exp_t e;
    logic dz;
    int   n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("idle_timeout", 64'(busy_o), 64'(0));
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
    @(posedge clk); #1;
    e.res = model(op, a, b, dz);
    e.dz = dz;
    e.acc_cyc = cyc;
    e.lat = dz ? 2 : W + 1;
    if (push) begin
      sb.push_back(e);
      last_res = e.res;
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Issue, then count busy cycles until the unit returns to IDLE.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic dz;
    logic [2*W-1:0] unused_r;
    issue(op, a, b, 1'b1);
    unused_r = model(op, a, b, dz);
    n = 0;
    while (busy_o && n < 200) begin n++; @(negedge clk); end
    check("busy_cycles", 64'(n), 64'(dz ? 2 : W + 1));
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset state.
    #12;
    check("reset_busy", 64'(busy_o), 64'(0));
    check("reset_ready", 64'(ready_o), 64'(0));
    check("reset_result", result_o, '0);
    check("reset_dz", 64'(div_by_zero_o), 64'(0));
    @(negedge clk); rst = 1'b1;

    // Directed cases from the test plan.
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0005);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd0);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b10, 32'd100, 32'd0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0007);

    // A start_i arriving during CALC is ignored.
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    start_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd5; opdata2_i = 32'd6;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    repeat (W + 4) @(negedge clk);

    // Annul on the 10th CALC cycle: no ready, result held.
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'(0));
    check("annul_result", result_o, last_res);
    repeat (W + 4) @(negedge clk);
    check("annul_result_held", result_o, last_res);

    // start_i together with annul_i in IDLE is refused.
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd9; opdata2_i = 32'd9;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("annul_start_busy", 64'(busy_o), 64'(0));
    repeat (W + 4) @(negedge clk);

    // Asynchronous reset between edges in the middle of CALC.
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'(0));
    check("arst_ready", 64'(ready_o), 64'(0));
    check("arst_result", result_o, '0);
    check("arst_dz", 64'(div_by_zero_o), 64'(0));
    @(negedge clk); rst = 1'b1;
    run_op(2'b01, 32'd3, 32'd4);

    // Randomized mix of all four ops.
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd());
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Iterative multiply/divide unit for the EX stage of the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over multiple cycles and returns a double-width {hi, lo} result for the HILO register. The ID/EX path holds the pipeline through busy_o. Operand width is parametrised so the same block serves the 32-bit core and narrower test configurations.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH; must be >= 4 and even
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (rst==0 resets)
start_i  input  1  request to begin an operation; sampled only in IDLE
op_i  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
opdata1_i  input  WIDTH  multiplicand / dividend; sampled with start_i
opdata2_i  input  WIDTH  multiplier / divisor; sampled with start_i
annul_i  input  1  abort current operation (branch flush / exception)
busy_o  output  1  operation in progress; the pipeline stalls on this
ready_o  output  1  one-cycle pulse: result_o is valid
result_o  output  2*WIDTH  MUL: full product; DIV: {remainder, quotient}
div_by_zero_o  output  1  qualifies ready_o: the last DIV/DIVU had divisor 0

Behaviour:
- Reset (async on rst==0): state=IDLE; busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0; counter and datapath registers cleared. This applies mid-operation as well; after release the unit is in IDLE.
- States: IDLE, CALC, DIVZERO, DONE.
- IDLE:
  - Transition: start_i=1 and annul_i=0 -> latch op and operands; go to CALC, or to DIVZERO if op is DIV/DIVU with opdata2_i==0.
  - Latching for signed ops: store absolute values and record the result signs.
  - start_i outside IDLE is ignored.
- CALC:
  - Exactly WIDTH cycles, one bit per cycle. MUL uses shift-add; DIV uses restoring shift-subtract.
  - Counter runs 0..WIDTH-1; on the last cycle go to DONE.
- DIVZERO: one cycle, then DONE. Result is forced to 0 and div_by_zero_o is set.
- DONE:
  - Sign correction is applied here.
  - ready_o=1 for this single cycle; next state is IDLE.
- Latency: for the accepting edge E, ready_o is high in the cycle after edge E+WIDTH+1 for a normal op, or E+2 for divide-by-zero.
- busy_o: 1 in CALC, DIVZERO and DONE; 0 in IDLE. The ID stage also stalls combinationally when issuing start_i.
- result_o and div_by_zero_o update on entry to DONE and hold until the next DONE or reset. div_by_zero_o is 0 for MUL ops.
- Sign rules:
  - MULT: product negated when the operand signs differ.
  - DIV: quotient negated when the signs differ; remainder takes the dividend's sign.
  - Unsigned ops: no correction.
- Overflow case: DIV of most-negative by -1 gives quotient 2^(WIDTH-1) wrapped (0x80000000 for 32 bits) and remainder 0; no flag.
- Full-range MULT (-2^(W-1) squared) fits in 2*WIDTH with no wrap.
- annul_i=1 in any state other than IDLE: next edge -> IDLE, busy_o=0, no ready_o pulse, result_o unchanged.
- annul_i together with start_i in IDLE: start is not accepted.
- annul_i in DONE: the ready pulse in that cycle still occurs, and the next state is IDLE.

Test Plan:
- WIDTH=32, MULT 0xFFFFFFFF * 0x00000005 -> ready_o 33 edges after acceptance, result_o=0xFFFFFFFF_FFFFFFFB, div_by_zero_o=0, busy_o high for 33 cycles.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> result_o=0xFFFFFFFE_00000001; MULT 0x80000000 * 0x80000000 -> 0x40000000_00000000.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3); DIV 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000.
- DIVU 100 / 0 -> ready_o two edges after acceptance, result_o=0, div_by_zero_o=1; a following DIVU 100 / 7 -> result_o={32'd2, 32'd14}, div_by_zero_o=0.
- Start DIVU 100 / 7, assert annul_i on the 10th CALC cycle -> busy_o=0 after next edge, no ready_o, result_o keeps its old value; start_i during CALC ignored (result reflects first op only).
- Drive rst=0 asynchronously mid-CALC (between edges) -> busy_o, ready_o, result_o, div_by_zero_o all 0 immediately; after release MULTU 3 * 4 -> result_o=12.
